// File: rtl/mul256_op_inv_seq_pkg.sv
// mul256 shared definitions: ALU select encoding,
// inverse sequencer state encoding and default widths.
package mul256_op_inv_seq_pkg;

  localparam int P_WIDTH_D = 260;
  localparam int N_BITS_D  = 256;
  localparam int TMO_W_D   = 12;

  typedef enum logic [3:0] {
    SEL_PASS_A   = 4'b0000,
    SEL_HALF     = 4'b0011,
    SEL_SUB      = 4'b0100,
    SEL_ADD      = 4'b0110,
    SEL_ADD_HALF = 4'b0111
  } alu_sel_e;

  typedef enum logic [2:0] {
    IDLE,
    CHK,
    UEV,
    VEV,
    CMP,
    FIXU,
    FIXV,
    FIN
  } state_e;

endpackage

// File: rtl/mul256_op_alu.sv
// mul256 ALU: add/sub/halve on the wide datapath.
// Halving is a logical shift; callers keep operands non-negative.
module mul256_op_alu
  import mul256_op_inv_seq_pkg::*;
#(
  parameter int W = P_WIDTH_D
) (
  input  alu_sel_e       sel,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [W-1:0]   y
);

  logic [W-1:0] sum;
  logic [W-1:0] diff;

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    y = a;
    case (sel)
      SEL_HALF:     y = {1'b0, a[W-1:1]};
      SEL_ADD_HALF: y = {1'b0, sum[W-1:1]};
      SEL_SUB:      y = diff;
      SEL_ADD:      y = sum;
      default:      y = a;
    endcase
  end

endmodule

// File: rtl/mul256_op_cmp.sv
// mul256 compare stage: unsigned a >= b.
module mul256_op_cmp
  import mul256_op_inv_seq_pkg::*;
#(
  parameter int W = P_WIDTH_D
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         ge
);

  assign ge = (a >= b);

endmodule

// File: rtl/mul256_op_inv_seq.sv
// Modular inverse r = a^-1 mod m, binary extended Euclid,
// one add/sub/halve step per cycle through the shared ALU.
module mul256_op_inv_seq
  import mul256_op_inv_seq_pkg::*;
#(
  parameter int P_WIDTH = P_WIDTH_D,
  parameter int N_BITS  = N_BITS_D,
  parameter int TMO_W   = TMO_W_D
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [N_BITS-1:0] a,
  input  logic [N_BITS-1:0] m,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [N_BITS-1:0] r
);

  localparam int XW = P_WIDTH - N_BITS;
  localparam logic [P_WIDTH-1:0] ZERO = '0;
  localparam logic [P_WIDTH-1:0] ONE  = P_WIDTH'(1);

  state_e state, state_n;

  logic [P_WIDTH-1:0] u, u_n;
  logic [P_WIDTH-1:0] v, v_n;
  logic [P_WIDTH-1:0] x1, x1_n;
  logic [P_WIDTH-1:0] x2, x2_n;
  logic [N_BITS-1:0]  mreg, mreg_n;
  logic [TMO_W-1:0]   tmo, tmo_n;
  logic [N_BITS-1:0]  r_n;
  logic               err_n;

  logic [P_WIDTH-1:0] mext;
  logic [P_WIDTH-1:0] alu_a;
  logic [P_WIDTH-1:0] alu_b;
  logic [P_WIDTH-1:0] alu_y;
  alu_sel_e           alu_sel;
  logic               u_ge_v;
  logic               in_loop;

  assign mext = {{XW{1'b0}}, mreg};

  mul256_op_alu #(.W(P_WIDTH)) u_alu (
    .sel (alu_sel),
    .a   (alu_a),
    .b   (alu_b),
    .y   (alu_y)
  );

  mul256_op_cmp #(.W(P_WIDTH)) u_cmp (
    .a  (u),
    .b  (v),
    .ge (u_ge_v)
  );

  assign in_loop = (state == CHK) || (state == UEV) ||
                   (state == VEV) || (state == CMP) ||
                   (state == FIXU) || (state == FIXV);

  assign busy = in_loop;
  assign done = (state == FIN);

  always_comb begin
    state_n = state;
    u_n     = u;
    v_n     = v;
    x1_n    = x1;
    x2_n    = x2;
    mreg_n  = mreg;
    tmo_n   = tmo;
    r_n     = r;
    err_n   = err;
    alu_sel = SEL_PASS_A;
    alu_a   = x1;
    alu_b   = mext;

    unique case (state)
      IDLE: begin
        if (start) begin
          mreg_n  = m;
          u_n     = {{XW{1'b0}}, a};
          v_n     = {{XW{1'b0}}, m};
          x1_n    = ONE;
          x2_n    = ZERO;
          tmo_n   = '0;
          state_n = CHK;
        end
      end
      CHK: begin
        if (u == ZERO || v == ZERO) begin
          err_n   = 1'b1;
          r_n     = '0;
          state_n = FIN;
        end else if (u == ONE) begin
          err_n   = 1'b0;
          r_n     = x1[N_BITS-1:0];
          state_n = FIN;
        end else if (v == ONE) begin
          err_n   = 1'b0;
          r_n     = x2[N_BITS-1:0];
          state_n = FIN;
        end else if (!u[0]) begin
          state_n = UEV;
        end else if (!v[0]) begin
          state_n = VEV;
        end else begin
          state_n = CMP;
        end
      end
      UEV: begin
        u_n     = {1'b0, u[P_WIDTH-1:1]};
        alu_a   = x1;
        alu_sel = x1[0] ? SEL_ADD_HALF : SEL_HALF;
        x1_n    = alu_y;
        state_n = CHK;
      end
      VEV: begin
        v_n     = {1'b0, v[P_WIDTH-1:1]};
        alu_a   = x2;
        alu_sel = x2[0] ? SEL_ADD_HALF : SEL_HALF;
        x2_n    = alu_y;
        state_n = CHK;
      end
      CMP: begin
        alu_sel = SEL_SUB;
        if (u_ge_v) begin
          u_n     = u - v;
          alu_a   = x1;
          alu_b   = x2;
          x1_n    = alu_y;
          state_n = FIXU;
        end else begin
          v_n     = v - u;
          alu_a   = x2;
          alu_b   = x1;
          x2_n    = alu_y;
          state_n = FIXV;
        end
      end
      FIXU: begin
        if (x1[P_WIDTH-1]) begin
          alu_a   = x1;
          alu_sel = SEL_ADD;
          x1_n    = alu_y;
        end
        state_n = CHK;
      end
      FIXV: begin
        if (x2[P_WIDTH-1]) begin
          alu_a   = x2;
          alu_sel = SEL_ADD;
          x2_n    = alu_y;
        end
        state_n = CHK;
      end
      FIN: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // watchdog overrides whatever the loop decided this cycle
    if (in_loop) begin
      tmo_n = tmo + 1'b1;
      if (&tmo) begin
        err_n   = 1'b1;
        r_n     = '0;
        state_n = FIN;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      u     <= '0;
      v     <= '0;
      x1    <= '0;
      x2    <= '0;
      mreg  <= '0;
      tmo   <= '0;
      r     <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      u     <= u_n;
      v     <= v_n;
      x1    <= x1_n;
      x2    <= x2_n;
      mreg  <= mreg_n;
      tmo   <= tmo_n;
      r     <= r_n;
      err   <= err_n;
    end
  end

endmodule

// File: tb/tb_mul256_op_inv_seq.sv
// Directed bench for mul256_op_inv_seq: vector table
// plus latency, start-spam and mid-op reset sequences.
module tb_mul256_op_inv_seq;

  localparam int N   = 256;
  localparam int BUD = 5000;

  typedef struct {
    logic [N-1:0] m;
    logic [N-1:0] a;
    logic [N-1:0] r;
    logic         err;
  } vec_t;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] m = '0;
  logic         busy;
  logic         done;
  logic         err;
  logic [N-1:0] r;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mul256_op_inv_seq dut (
    .clk   (clk),
    .rstn  (rstn),
    .start (start),
    .a     (a),
    .m     (m),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .r     (r)
  );

  task automatic check(input string name,
                       input logic [N-1:0] act,
                       input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // returns cycles from the start-sampling edge to the done cycle
  task automatic run_op(input logic [N-1:0] mm,
                        input logic [N-1:0] aa,
                        output int cyc);
    @(negedge clk);
    m = mm;
    a = aa;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < BUD) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL timeout: no done after %0d cycles", cyc);
    end
  endtask

  vec_t vecs[11];
  logic [N-1:0] m25519;
  logic [N-1:0] half;
  int cyc;
  int dones;

  initial begin
    vecs[0]  = '{m: 7,   a: 3,  r: 5,  err: 1'b0};
    vecs[1]  = '{m: 13,  a: 1,  r: 1,  err: 1'b0};
    vecs[2]  = '{m: 15,  a: 5,  r: 0,  err: 1'b1};
    vecs[3]  = '{m: 11,  a: 0,  r: 0,  err: 1'b1};
    vecs[4]  = '{m: 11,  a: 2,  r: 6,  err: 1'b0};
    vecs[5]  = '{m: 17,  a: 3,  r: 6,  err: 1'b0};
    vecs[6]  = '{m: 101, a: 10, r: 91, err: 1'b0};
    vecs[7]  = '{m: 3,   a: 2,  r: 2,  err: 1'b0};
    vecs[8]  = '{m: 15,  a: 7,  r: 13, err: 1'b0};
    vecs[9]  = '{m: 9,   a: 6,  r: 0,  err: 1'b1};
    vecs[10] = '{m: 3,   a: 1,  r: 1,  err: 1'b0};

    m25519 = (N'(1) << 255) - N'(19);
    half   = (N'(1) << 254) - N'(9);

    repeat (2) @(negedge clk);
    check("rst_busy", N'(busy), N'(0));
    check("rst_done", N'(done), N'(0));
    check("rst_err",  N'(err),  N'(0));
    check("rst_r",    r,        N'(0));
    rstn = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].m, vecs[i].a, cyc);
      check($sformatf("vec%0d_r", i), r, vecs[i].r);
      check($sformatf("vec%0d_err", i), N'(err), N'(vecs[i].err));
      check($sformatf("vec%0d_busy", i), N'(busy), N'(0));
    end

    run_op(13, 1, cyc);
    check("lat_min", N'(cyc + 1), N'(3));
    check("lat_min_r", r, N'(1));
    repeat (3) @(negedge clk);
    check("r_held", r, N'(1));
    check("done_pulse", N'(done), N'(0));

    run_op(m25519, 2, cyc);
    check("big_r", r, half);
    check("big_err", N'(err), N'(0));
    check("big_lat", N'(cyc < 1030), N'(1));

    run_op(m25519, m25519 - N'(1), cyc);
    check("big_m1_r", r, m25519 - N'(1));
    check("big_m1_err", N'(err), N'(0));

    // start held high every busy cycle; a/m changed mid-op
    @(negedge clk);
    m = 7;
    a = 3;
    start = 1'b1;
    @(negedge clk);
    a = 2;
    m = 11;
    dones = 0;
    cyc = 1;
    while (!done && cyc < BUD) begin
      @(negedge clk);
      cyc++;
    end
    if (done) dones++;
    check("spam_r", r, N'(5));
    check("spam_err", N'(err), N'(0));
    @(negedge clk);
    check("spam_fin_ignored", N'(busy), N'(0));
    start = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("spam_dones", N'(dones), N'(1));

    // async reset in the middle of an operation
    @(negedge clk);
    m = 7;
    a = 3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_busy", N'(busy), N'(1));
    #2 rstn = 1'b0;
    #1;
    check("arst_busy", N'(busy), N'(0));
    check("arst_done", N'(done), N'(0));
    check("arst_err",  N'(err),  N'(0));
    check("arst_r",    r,        N'(0));
    @(negedge clk);
    rstn = 1'b1;
    run_op(7, 3, cyc);
    check("post_rst_r", r, N'(5));
    check("post_rst_err", N'(err), N'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
